// File: rtl/mem_io_responder_if.sv
// CPU bus, UART RX and UART TX signals of the memory/IO responder.
// The responder takes the slave side; the CPU/UART environment takes the master side.
interface mem_io_responder_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 8;

  logic              rdy_in;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_dout;
  logic [DATA_W-1:0] mem_din;
  logic              io_buffer_full;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              rx_pop;
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready;
  logic              program_finish;
  logic              tx_overflow;

  modport master (
    output rdy_in, mem_a, mem_wr, mem_dout, rx_valid, rx_data, tx_ready,
    input  mem_din, io_buffer_full, rx_pop, tx_valid, tx_data, program_finish, tx_overflow
  );

  modport slave (
    input  rdy_in, mem_a, mem_wr, mem_dout, rx_valid, rx_data, tx_ready,
    output mem_din, io_buffer_full, rx_pop, tx_valid, tx_data, program_finish, tx_overflow
  );
endinterface

// File: rtl/mem_io_responder.sv
// CPU-side RAM plus memory-mapped UART RX/TX, cycle counter and halt port.
// Reads return one cycle later on mem_din; TX bytes queue in a small FIFO.
module mem_io_responder #(
  parameter int unsigned RAM_ADDR_W  = 17,
  parameter int unsigned TX_DEPTH    = 16,
  parameter int unsigned FULL_MARGIN = 2
) (
  input logic               clk_in,
  input logic               rst_in,
  mem_io_responder_if.slave bus
);
  localparam int unsigned RAM_WORDS = 1 << RAM_ADDR_W;
  localparam int unsigned PTR_W     = $clog2(TX_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned DEC_W     = 18;

  localparam logic [DEC_W-1:0] IO_RX   = 18'h30000;
  localparam logic [DEC_W-1:0] IO_CNT0 = 18'h30004;
  localparam logic [DEC_W-1:0] IO_CNT1 = 18'h30005;
  localparam logic [DEC_W-1:0] IO_CNT2 = 18'h30006;
  localparam logic [DEC_W-1:0] IO_CNT3 = 18'h30007;

  logic [DEC_W-1:0] a;
  logic             unused_addr_hi;
  logic             acc, rd, wr, is_ram;

  logic [7:0]       ram [RAM_WORDS];
  logic [7:0]       fifo [TX_DEPTH];
  logic [31:0]      cycle_cnt, snapshot;
  logic             halted;

  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_next;
  logic [CNT_W-1:0] count, count_next, remain;
  logic [7:0]       push_byte, head_next, rd_byte;
  logic             push, pop, accept, pf_set;

  // Only the low 18 address bits take part in decode; accesses in reset are ignored.
  assign a              = bus.mem_a[DEC_W-1:0];
  assign unused_addr_hi = ^bus.mem_a[31:DEC_W];
  assign acc            = rst_in && bus.rdy_in;
  assign rd             = acc && !bus.mem_wr;
  assign wr             = acc && bus.mem_wr;
  assign is_ram         = ~a[17];

  // IO write decode: 0x30000 queues a nonzero byte, 0x30004 queues 0x00 and halts.
  always_comb begin
    push      = 1'b0;
    pf_set    = 1'b0;
    push_byte = bus.mem_dout;
    if (wr && !halted) begin
      if (a == IO_RX && bus.mem_dout != 8'h00) begin
        push = 1'b1;
      end else if (a == IO_CNT0) begin
        push      = 1'b1;
        push_byte = 8'h00;
        pf_set    = 1'b1;
      end
    end
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop    = bus.tx_valid && bus.tx_ready;
  assign accept = push && ((count != CNT_W'(TX_DEPTH)) || pop);

  // Next head byte: an older entry if one remains, otherwise the byte being pushed.
  always_comb begin
    rd_next    = rd_ptr + PTR_W'(pop);
    remain     = count - CNT_W'(pop);
    count_next = remain + CNT_W'(accept);
    head_next  = bus.tx_data;
    if (remain != '0) begin
      head_next = fifo[rd_next];
    end else if (accept) begin
      head_next = push_byte;
    end
  end

  // Read data mux; unmapped and unused IO addresses read as zero.
  always_comb begin
    rd_byte = 8'h00;
    if (is_ram) begin
      rd_byte = ram[a[RAM_ADDR_W-1:0]];
    end else begin
      case (a)
        IO_RX:   rd_byte = bus.rx_valid ? bus.rx_data : 8'h00;
        IO_CNT0: rd_byte = cycle_cnt[7:0];
        IO_CNT1: rd_byte = snapshot[15:8];
        IO_CNT2: rd_byte = snapshot[23:16];
        IO_CNT3: rd_byte = snapshot[31:24];
        default: rd_byte = 8'h00;
      endcase
    end
  end

  // Storage arrays carry no reset.
  always_ff @(posedge clk_in) begin
    if (wr && is_ram) begin
      ram[a[RAM_ADDR_W-1:0]] <= bus.mem_dout;
    end
    if (accept) begin
      fifo[wr_ptr] <= push_byte;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      bus.mem_din        <= 8'h00;
      bus.rx_pop         <= 1'b0;
      bus.tx_valid       <= 1'b0;
      bus.tx_data        <= 8'h00;
      bus.io_buffer_full <= 1'b0;
      bus.program_finish <= 1'b0;
      bus.tx_overflow    <= 1'b0;
      cycle_cnt          <= '0;
      snapshot           <= '0;
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      count              <= '0;
      halted             <= 1'b0;
    end else begin
      cycle_cnt          <= cycle_cnt + 32'd1;
      bus.rx_pop         <= 1'b0;
      bus.program_finish <= pf_set;
      if (rd) begin
        bus.mem_din <= rd_byte;
        if (a == IO_RX && bus.rx_valid) bus.rx_pop <= 1'b1;
        if (a == IO_CNT0)               snapshot   <= cycle_cnt;
      end
      if (pf_set)            halted          <= 1'b1;
      if (push && !accept)   bus.tx_overflow <= 1'b1;
      wr_ptr             <= wr_ptr + PTR_W'(accept);
      rd_ptr             <= rd_next;
      count              <= count_next;
      bus.tx_valid       <= (count_next != '0);
      bus.tx_data        <= head_next;
      bus.io_buffer_full <= (count >= CNT_W'(TX_DEPTH - FULL_MARGIN));
    end
  end
endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench for mem_io_responder: read and TX expectations are queued by
// the stimulus and consumed by monitors when the DUT presents data.
module tb_mem_io_responder;
  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   tx_hs = 0;
  int   pf_cnt = 0;

  typedef struct {
    logic [7:0] din;
    logic       pop;
    string      name;
  } rd_exp_t;

  rd_exp_t    rd_q[$];
  logic [7:0] tx_q[$];
  bit         rd_chk   = 1'b0;
  bit         rd_chk_q = 1'b0;

  mem_io_responder_if bus ();

  mem_io_responder #(
    .RAM_ADDR_W (17),
    .TX_DEPTH   (16),
    .FULL_MARGIN(2)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Read-data monitor: one queued expectation per flagged cycle.
  always @(posedge clk) rd_chk_q <= rd_chk;

  always @(negedge clk) begin
    if (rd_chk_q) begin
      if (rd_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_q_underflow: actual=empty required=entry");
      end else begin
        rd_exp_t it;
        it = rd_q.pop_front();
        check({it.name, "_din"}, 32'(bus.mem_din), 32'(it.din));
        check({it.name, "_pop"}, 32'(bus.rx_pop), 32'(it.pop));
      end
    end else if (rst === 1'b1) begin
      check("rx_pop_idle", 32'(bus.rx_pop), 32'd0);
    end
  end

  // TX monitor: every handshake must match the oldest queued byte.
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
      tx_hs++;
      if (tx_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL tx_unexpected: actual=%0h required=none", bus.tx_data);
      end else begin
        check("tx_byte", 32'(bus.tx_data), 32'(tx_q.pop_front()));
      end
    end
    if (bus.program_finish === 1'b1) pf_cnt++;
  end

  task automatic acc(input bit rdy, input logic [31:0] addr, input bit w, input logic [7:0] d,
                     input bit chk, input logic [7:0] edin, input bit epop, input string nm);
    bus.rdy_in   = rdy;
    bus.mem_a    = addr;
    bus.mem_wr   = w;
    bus.mem_dout = d;
    if (chk) rd_q.push_back('{edin, epop, nm});
    rd_chk = chk;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) acc(1'b0, 32'h0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, "");
  endtask

  task automatic wr(input logic [31:0] addr, input logic [7:0] d);
    acc(1'b1, addr, 1'b1, d, 1'b0, 8'h00, 1'b0, "");
  endtask

  task automatic rd(input logic [31:0] addr, input logic [7:0] e, input string nm);
    acc(1'b1, addr, 1'b0, 8'h00, 1'b1, e, 1'b0, nm);
  endtask

  task automatic wr_tx(input logic [7:0] d);
    tx_q.push_back(d);
    wr(32'h30000, d);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    bus.rdy_in = 1'b0; bus.mem_a = '0; bus.mem_wr = 1'b0; bus.mem_dout = '0;
    bus.rx_valid = 1'b0; bus.rx_data = '0; bus.tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_din",  32'(bus.mem_din), 32'd0);
    check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_ibf",      32'(bus.io_buffer_full), 32'd0);
    check("rst_ovf",      32'(bus.tx_overflow), 32'd0);
    check("rst_pf",       32'(bus.program_finish), 32'd0);
    check("rst_tx_data",  32'(bus.tx_data), 32'd0);
    rst = 1'b1;

    // RAM, read latency, hold and decode
    wr(32'h00100, 8'hA5);
    rd(32'h00100, 8'hA5, "ram_raw");
    acc(1'b0, 32'h00100, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b0, "hold_nordy");
    acc(1'b1, 32'h00200, 1'b1, 8'h5A, 1'b1, 8'hA5, 1'b0, "hold_write");
    rd(32'h00200, 8'h5A, "ram_b");
    wr(32'h1FFFF, 8'h33);
    rd(32'h1FFFF, 8'h33, "ram_top");
    wr(32'h20010, 8'h77);
    rd(32'h20010, 8'h00, "unmapped");
    rd(32'h30001, 8'h00, "io_gap");
    rd(32'hFFFC0100, 8'hA5, "addr_hi_ignored");

    // TX: nonzero byte queued, zero ignored, stray IO writes dropped
    bus.tx_ready = 1'b1;
    wr_tx(8'h41);
    wr(32'h30000, 8'h00);
    wr(32'h30001, 8'h55);
    wr(32'h20000, 8'h66);
    idle(3);
    check("tx_hs_single", 32'(tx_hs), 32'd1);

    // TX fill to near-full, full, and overflow
    bus.tx_ready = 1'b0;
    for (int i = 1; i <= 13; i++) wr_tx(8'(i));
    idle(1);
    check("ibf_at_13", 32'(bus.io_buffer_full), 32'd0);
    wr_tx(8'h0E);
    idle(1);
    check("ibf_at_14", 32'(bus.io_buffer_full), 32'd1);
    wr_tx(8'h0F);
    wr_tx(8'h10);
    check("ovf_at_16", 32'(bus.tx_overflow), 32'd0);
    wr(32'h30000, 8'h11);
    idle(1);
    check("ovf_at_17", 32'(bus.tx_overflow), 32'd1);
    bus.tx_ready = 1'b1;
    idle(20);
    check("tx_hs_drain", 32'(tx_hs), 32'd17);
    check("ibf_drained", 32'(bus.io_buffer_full), 32'd0);
    check("tx_valid_drained", 32'(bus.tx_valid), 32'd0);
    check("ovf_sticky", 32'(bus.tx_overflow), 32'd1);
    wr_tx(8'h21);
    wr_tx(8'h22);
    wr_tx(8'h23);
    idle(3);
    check("tx_hs_stream", 32'(tx_hs), 32'd20);

    // UART RX pop
    bus.rx_valid = 1'b1; bus.rx_data = 8'h7E;
    acc(1'b1, 32'h30000, 1'b0, 8'h00, 1'b1, 8'h7E, 1'b1, "rx_valid");
    acc(1'b0, 32'h30000, 1'b0, 8'h00, 1'b1, 8'h7E, 1'b0, "rx_one_pulse");
    bus.rx_valid = 1'b0;
    rd(32'h30000, 8'h00, "rx_empty");

    // Halt: one pulse, 0x00 sent, later IO writes ignored, RAM still live
    tx_q.push_back(8'h00);
    wr(32'h30004, 8'hFF);
    idle(3);
    check("pf_once", 32'(pf_cnt), 32'd1);
    check("tx_hs_halt", 32'(tx_hs), 32'd21);
    wr(32'h30000, 8'h42);
    wr(32'h30004, 8'h01);
    idle(3);
    check("tx_hs_halted", 32'(tx_hs), 32'd21);
    check("pf_halted", 32'(pf_cnt), 32'd1);
    wr(32'h00300, 8'h99);
    rd(32'h00300, 8'h99, "ram_halted");

    // Reset: RAM kept, access during reset ignored, FIFO cleared
    rst = 1'b0;
    wr(32'h00100, 8'hEE);
    idle(1);
    rst = 1'b1;
    rd(32'h00100, 8'hA5, "ram_after_rst");
    bus.tx_ready = 1'b0;
    wr(32'h30000, 8'h61);
    wr(32'h30000, 8'h62);
    wr(32'h30000, 8'h63);
    check("tx_valid_pre_rst", 32'(bus.tx_valid), 32'd1);
    check("tx_head_pre_rst", 32'(bus.tx_data), 32'h61);
    rst = 1'b0;
    idle(1);
    check("tx_valid_mid_rst", 32'(bus.tx_valid), 32'd0);
    check("tx_data_mid_rst", 32'(bus.tx_data), 32'd0);
    check("ovf_mid_rst", 32'(bus.tx_overflow), 32'd0);
    rst = 1'b1;
    bus.tx_ready = 1'b1;
    idle(3);
    check("tx_hs_flushed", 32'(tx_hs), 32'd21);
    wr_tx(8'h55);
    idle(3);
    check("tx_hs_unhalted", 32'(tx_hs), 32'd22);

    // Cycle counter and snapshot
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    rd(32'h30004, 8'h00, "cnt_start");
    idle(32'h122);
    rd(32'h30004, 8'h23, "cnt_b0");
    rd(32'h30005, 8'h01, "cnt_b1");
    acc(1'b0, 32'h30006, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, "cnt_hold");
    rd(32'h30006, 8'h00, "cnt_b2");
    rd(32'h30007, 8'h00, "cnt_b3");
    idle(32'h100);
    rd(32'h30005, 8'h01, "cnt_snap_kept");
    idle(2);

    check("rd_q_drained", 32'(rd_q.size()), 32'd0);
    check("tx_q_drained", 32'(tx_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
